pe_row_ctx_ctrl: RTL and testbench
==================================

# pe_row_ctx_ctrl

Multi-context configuration and run controller for one parametrised CGRA PE row: one LSU plus `NUM_PE` PEs. It stores `CTX_DEPTH` complete row configurations, one instruction word per element, loaded through a valid/ready stream. On `start` it broadcasts the selected context to the row with one-hot init strobes, then holds `run` until stopped or switched to another context. It sits between the array-level config fabric and the row datapath, replacing fixed 5-bit `init_sel` generation.

## Interface
- `NUM_PE`, default 4: PEs in the row. The row has `NUM_PE+1` elements including the LSU.
- `INST_W`, default 32: instruction word width, equal to the `PE_config` width.
- `CTX_DEPTH`, default 4: number of stored contexts; must be at least 2.
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-low reset.
- `cfg_valid` in 1: config word offered.
- `cfg_ready` out 1: config word can be accepted.
- `cfg_ctx` in `$clog2(CTX_DEPTH)`: target context.
- `cfg_slot` in `$clog2(NUM_PE+1)`: target element; 0 = LSU, k = PE(k-1).
- `cfg_data` in `INST_W`: instruction word.
- `start` in 1: pulse; load and run context `ctx_sel`.
- `ctx_sel` in `$clog2(CTX_DEPTH)`: context to start; sampled with `start`.
- `stop` in 1: pulse; end the run.
- `PE_config` out `INST_W`: broadcast instruction.
- `init_en` out 1: init strobe qualifier.
- `init_sel` out `NUM_PE+1`: one-hot element select. MSB = LSU, next = PE0, bit 0 = PE(NUM_PE-1).
- `run` out 1: row run enable.
- `busy` out 1: state is not IDLE.
- `done` out 1: one-cycle pulse when a run ends.
- `cfg_err` out 1: sticky; set by an out-of-range slot write.

## Operation
- Storage: `CTX_DEPTH*(NUM_PE+1)` words of `INST_W`, all cleared to 0 on reset.
- Write handshake: a write occurs when `cfg_valid && cfg_ready`.
  - `cfg_ready` = (state==IDLE) || (`cfg_ctx` != `active_ctx`). Background loading of inactive contexts is therefore allowed while the row runs.
- A `cfg_slot` > `NUM_PE` write is still accepted (handshake completes) but dropped, and it sets `cfg_err`. Only reset clears `cfg_err`.
- FSM states: IDLE, LOAD, RUN, DRAIN.
  - IDLE: on `start`, latch `active_ctx`=`ctx_sel`, set slot counter = 0, go to LOAD.
  - LOAD: each cycle drive `PE_config`=mem[`active_ctx`][slot], `init_en`=1, and `init_sel` one-hot for that slot. Slot increments by 1. After slot `NUM_PE`, go to RUN. `start` and `stop` are ignored in LOAD.
  - RUN: `run`=1.
    - On `stop`: go to IDLE, `run`=0, `done`=1 for one cycle.
    - On `start` without `stop`: latch new `active_ctx`, go to DRAIN. If `ctx_sel` equals the current context, this reloads it.
    - If `stop` and `start` arrive together, `stop` wins and `start` is discarded.
  - DRAIN: `run`=0 for one cycle, `done`=1 for that cycle, then LOAD with slot = 0.
- Outside LOAD: `init_en`=0, `init_sel`=0, `PE_config`=0.
- Same-cycle write to the slot being read in LOAD: impossible, because `active_ctx` is write-blocked.

## Timing
- All outputs are registered except `cfg_ready`, which is combinational from state, `active_ctx` and `cfg_ctx`.
- Reset values: `PE_config`=0, `init_en`=0, `init_sel`=0, `run`=0, `busy`=0, `done`=0, `cfg_err`=0, state IDLE. `cfg_ready`=1.
- `start` sampled at edge t:
  - LOAD outputs appear for cycles t+1 … t+NUM_PE+1.
  - `run`=1 from t+NUM_PE+2.
- Written word visibility: a word written at edge w is visible to any LOAD cycle after w.
- `stop` sampled at edge s in RUN: `run`=0 and `done`=1 in cycle s+1; `busy`=0 at s+1.
- Context switch sampled at s: DRAIN in cycle s+1, LOAD in cycles s+2 … s+NUM_PE+2, `run` again at s+NUM_PE+3.
- Reset mid-LOAD or mid-RUN: all outputs clear immediately (asynchronous); memory is cleared.

## Structure
- Shared package holds:
  - FSM state enum (IDLE/LOAD/RUN/DRAIN, 2 bits);
  - slot-index helper constant `LSU_SLOT`=0;
  - `INST_W` default aligned to the global `PE_inst` width.
- One sub-module: `ctx_cfg_mem`, the context storage with one write port, one read port, and reset clear. The FSM, handshake, and one-hot decode stay in the top.

## Test plan
- Reset, then write ctx 1 slots 0..4 = 0xA0..0xA4 and start ctx 1 → `init_sel` 10000,01000,00100,00010,00001 with `PE_config` 0xA0..0xA4 in cycles t+1..t+5; `run`=1 at t+6.
- RUN on ctx 1; write ctx 2 slot 3 = 0x55 (`cfg_ready`=1); write ctx 1 → `cfg_ready`=0 and the write stalls until IDLE.
- RUN; `stop` at s → `run`=0 and `done`=1 at s+1; `busy`=0.
- RUN ctx 1; `start` with ctx 2 → DRAIN one cycle, then LOAD shows 0x55 on `init_sel`=00010; `run` at s+7.
- `stop` and `start` in the same RUN cycle → stops; no LOAD follows.
- Write slot 6 with `NUM_PE`=4 → handshake completes, `cfg_err`=1, memory unchanged; async reset mid-LOAD → all outputs 0 that cycle.

Source files
------------

// File: rtl/pe_row_ctx_ctrl_pkg.sv
// Shared types and constants for the PE-row multi-context configuration controller.
package pe_row_ctx_ctrl_pkg;

  // Kept equal to the global PE instruction width.
  localparam int PE_INST_W = 32;
  localparam int LSU_SLOT  = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

endpackage

// File: rtl/pe_row_ctx_ctrl_ctx_cfg_mem.sv
// Context storage: CTX_DEPTH rows of NUM_SLOTS instruction words.
// One write port, one asynchronous read port, and a clear on reset.
module ctx_cfg_mem #(
  parameter int NUM_SLOTS = 5,
  parameter int CTX_DEPTH = 4,
  parameter int INST_W    = 32,
  parameter int CTX_W     = 2,
  parameter int SLOT_W    = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [CTX_W-1:0]  wctx_i,
  input  logic [SLOT_W-1:0] wslot_i,
  input  logic [INST_W-1:0] wdata_i,
  input  logic [CTX_W-1:0]  rctx_i,
  input  logic [SLOT_W-1:0] rslot_i,
  output logic [INST_W-1:0] rdata_o
);

  logic [INST_W-1:0] mem_q [CTX_DEPTH][NUM_SLOTS];

  // NOTE: the storage is cleared by reset, so it must be flops rather than a RAM macro.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CTX_DEPTH; c++) begin
        for (int s = 0; s < NUM_SLOTS; s++) begin
          mem_q[c][s] <= '0;
        end
      end
    end else if (we_i) begin
      mem_q[wctx_i][wslot_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rctx_i][rslot_i];

endmodule

// File: rtl/pe_row_ctx_ctrl.sv
// Multi-context config/run controller for one CGRA PE row (LSU + NUM_PE PEs).
// Loads stored contexts via one-hot init strobes, then holds run until stop or switch.
module pe_row_ctx_ctrl
  import pe_row_ctx_ctrl_pkg::*;
#(
  parameter  int NUM_PE    = 4,
  parameter  int INST_W    = PE_INST_W,
  parameter  int CTX_DEPTH = 4,
  localparam int NUM_SLOTS = NUM_PE + 1,
  localparam int CTX_W     = $clog2(CTX_DEPTH),
  localparam int SLOT_W    = $clog2(NUM_PE + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [CTX_W-1:0]     cfg_ctx,
  input  logic [SLOT_W-1:0]    cfg_slot,
  input  logic [INST_W-1:0]    cfg_data,
  input  logic                 start,
  input  logic [CTX_W-1:0]     ctx_sel,
  input  logic                 stop,
  output logic [INST_W-1:0]    PE_config,
  output logic                 init_en,
  output logic [NUM_SLOTS-1:0] init_sel,
  output logic                 run,
  output logic                 busy,
  output logic                 done,
  output logic                 cfg_err
);

  localparam logic [SLOT_W-1:0]    LAST_SLOT  = SLOT_W'(NUM_PE);
  localparam logic [SLOT_W-1:0]    FIRST_SLOT = SLOT_W'(LSU_SLOT);
  localparam logic [NUM_SLOTS-1:0] SEL_LSU    = {1'b1, {NUM_PE{1'b0}}};

  state_e              state_q, state_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [CTX_W-1:0]    ctx_q, ctx_d;
  logic [INST_W-1:0]   pe_config_q, pe_config_d;
  logic [NUM_SLOTS-1:0] init_sel_q, init_sel_d;
  logic                init_en_q, init_en_d;
  logic                run_q, run_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                cfg_err_q, cfg_err_d;

  logic                cfg_fire, slot_ok, mem_we;
  logic [INST_W-1:0]   mem_rdata, rd_data;

  // The running context is write-protected; other contexts may load in the background.
  assign cfg_ready = (state_q == ST_IDLE) || (cfg_ctx != ctx_q);
  assign cfg_fire  = cfg_valid && cfg_ready;
  assign slot_ok   = (cfg_slot <= LAST_SLOT);
  assign mem_we    = cfg_fire && slot_ok;

  ctx_cfg_mem #(
    .NUM_SLOTS (NUM_SLOTS),
    .CTX_DEPTH (CTX_DEPTH),
    .INST_W    (INST_W),
    .CTX_W     (CTX_W),
    .SLOT_W    (SLOT_W)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst),
    .we_i    (mem_we),
    .wctx_i  (cfg_ctx),
    .wslot_i (cfg_slot),
    .wdata_i (cfg_data),
    .rctx_i  (ctx_d),
    .rslot_i (slot_d),
    .rdata_o (mem_rdata)
  );

  // NOTE: every signal assigned here gets a default first, so no latch can be inferred.
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    ctx_d   = ctx_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          ctx_d   = ctx_sel;
          slot_d  = FIRST_SLOT;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (slot_q == LAST_SLOT) state_d = ST_RUN;
        else                     slot_d  = slot_q + 1'b1;
      end
      ST_RUN: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (start) begin
          ctx_d   = ctx_sel;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        slot_d  = FIRST_SLOT;
        state_d = ST_LOAD;
      end
    endcase

    // Outputs are registered from the next state; a word written this edge is forwarded.
    rd_data     = (mem_we && cfg_ctx == ctx_d && cfg_slot == slot_d) ? cfg_data : mem_rdata;
    init_en_d   = (state_d == ST_LOAD);
    pe_config_d = init_en_d ? rd_data : '0;
    init_sel_d  = init_en_d ? (SEL_LSU >> slot_d) : '0;
    run_d       = (state_d == ST_RUN);
    busy_d      = (state_d != ST_IDLE);
    done_d      = ((state_q == ST_RUN) && (state_d == ST_IDLE)) || (state_d == ST_DRAIN);
    cfg_err_d   = cfg_err_q || (cfg_fire && !slot_ok);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      slot_q      <= '0;
      ctx_q       <= '0;
      pe_config_q <= '0;
      init_sel_q  <= '0;
      init_en_q   <= 1'b0;
      run_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      ctx_q       <= ctx_d;
      pe_config_q <= pe_config_d;
      init_sel_q  <= init_sel_d;
      init_en_q   <= init_en_d;
      run_q       <= run_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign PE_config = pe_config_q;
  assign init_en   = init_en_q;
  assign init_sel  = init_sel_q;
  assign run       = run_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_pe_row_ctx_ctrl.sv
// Self-checking bench for pe_row_ctx_ctrl: directed test-plan steps with literal
// expectations, then randomized traffic checked every cycle against a timeline model.
module tb_pe_row_ctx_ctrl;

  localparam int NP = 4;
  localparam int IW = 32;
  localparam int CD = 4;
  localparam int CW = 2;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [CW-1:0] cfg_ctx = '0;
  logic [SW-1:0] cfg_slot = '0;
  logic [IW-1:0] cfg_data = '0;
  logic          start = 1'b0;
  logic [CW-1:0] ctx_sel = '0;
  logic          stop = 1'b0;
  logic [IW-1:0] PE_config;
  logic          init_en;
  logic [NP:0]   init_sel;
  logic          run, busy, done, cfg_err;

  always #5 clk = ~clk;

  pe_row_ctx_ctrl #(.NUM_PE(NP), .INST_W(IW), .CTX_DEPTH(CD)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ctx   (cfg_ctx),
    .cfg_slot  (cfg_slot),
    .cfg_data  (cfg_data),
    .start     (start),
    .ctx_sel   (ctx_sel),
    .stop      (stop),
    .PE_config (PE_config),
    .init_en   (init_en),
    .init_sel  (init_sel),
    .run       (run),
    .busy      (busy),
    .done      (done),
    .cfg_err   (cfg_err)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Timeline model: a started context occupies load periods load_from..load_from+NP,
  // then runs until stopped; period p means the cycle following clock edge p.
  logic [IW-1:0] mem_m [CD][NP+1];
  bit  engaged;
  bit  err_m;
  int  act_m;
  int  k = 0;
  int  load_from, drain_at, done_at;

  function automatic bit in_load(int p);
    return engaged && p >= load_from && p <= load_from + NP;
  endfunction

  function automatic bit in_run(int p);
    return engaged && p > load_from + NP;
  endfunction

  function automatic bit exp_ready();
    return !engaged || (cfg_ctx != CW'(act_m));
  endfunction

  task automatic model_reset();
    for (int c = 0; c < CD; c++)
      for (int s = 0; s <= NP; s++) mem_m[c][s] = '0;
    engaged = 0; err_m = 0; act_m = 0;
    load_from = -100; drain_at = -100; done_at = -100;
  endtask

  task automatic model_edge();
    int prev;
    k++;
    if (!rst) return;
    prev = k - 1;
    if (cfg_valid && exp_ready()) begin
      if (int'(cfg_slot) <= NP) mem_m[cfg_ctx][cfg_slot] = cfg_data;
      else                      err_m = 1;
    end
    if (!engaged) begin
      if (start) begin
        engaged = 1; act_m = int'(ctx_sel); load_from = k;
      end
    end else if (in_run(prev)) begin
      if (stop) begin
        engaged = 0; done_at = k;
      end else if (start) begin
        act_m = int'(ctx_sel); drain_at = k; load_from = k + 1;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  bit              cmp_en = 0;
  bit              c_ld;
  int              c_sl;
  logic [31:0]     c_sel, c_cfg;
  always @(negedge clk) begin
    if (cmp_en) begin
      c_ld  = in_load(k);
      c_sl  = k - load_from;
      c_sel = 32'd0;
      c_cfg = 32'd0;
      if (c_ld) begin
        c_sel = 32'd1 << (NP - c_sl);
        c_cfg = mem_m[act_m][c_sl];
      end
      check("m_init_en",   init_en,   c_ld);
      check("m_init_sel",  init_sel,  c_sel);
      check("m_PE_config", PE_config, c_cfg);
      check("m_run",       run,       in_run(k));
      check("m_busy",      busy,      engaged);
      check("m_done",      done,      (done_at == k) || (engaged && drain_at == k));
      check("m_cfg_err",   cfg_err,   err_m);
      check("m_cfg_ready", cfg_ready, exp_ready());
    end
  end

  initial begin
    model_reset();
    repeat (3) step();
    check("rst_init_en", init_en, 0);
    check("rst_init_sel", init_sel, 0);
    check("rst_PE_config", PE_config, 0);
    check("rst_run", run, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_cfg_err", cfg_err, 0);
    check("rst_cfg_ready", cfg_ready, 1);
    rst = 1'b1;
    cmp_en = 1;

    // Load ctx 1 with A0..A4 and start it.
    for (int i = 0; i <= NP; i++) begin
      cfg_valid = 1; cfg_ctx = 2'd1; cfg_slot = SW'(i); cfg_data = 32'hA0 + i;
      step();
    end
    cfg_valid = 0;
    start = 1; ctx_sel = 2'd1;
    step();
    start = 0;
    check("load0_sel", init_sel, 5'b10000);
    check("load0_cfg", PE_config, 32'hA0);
    for (int i = 1; i <= NP; i++) begin
      step();
      check("loadn_sel", init_sel, 5'b10000 >> i);
      check("loadn_cfg", PE_config, 32'hA0 + i);
    end
    step();
    check("run_after_load", run, 1);

    // Background write to ctx 2 is accepted; write to the active ctx stalls.
    cfg_valid = 1; cfg_ctx = 2'd2; cfg_slot = 3'd3; cfg_data = 32'h55;
    #1 check("bg_ready", cfg_ready, 1);
    step();
    cfg_valid = 1; cfg_ctx = 2'd1; cfg_slot = 3'd0; cfg_data = 32'hEE;
    #1 check("active_blocked", cfg_ready, 0);
    step(); step();
    check("still_blocked", cfg_ready, 0);
    stop = 1;
    step();
    stop = 0;
    check("stop_run", run, 0);
    check("stop_done", done, 1);
    check("stop_busy", busy, 0);
    check("idle_ready", cfg_ready, 1);
    step();
    cfg_valid = 0;

    // Restart ctx 1, then switch to ctx 2 mid-run.
    start = 1; ctx_sel = 2'd1;
    step();
    start = 0;
    check("reload_cfg", PE_config, 32'hEE);
    repeat (NP + 1) step();
    check("rerun", run, 1);
    start = 1; ctx_sel = 2'd2;
    step();
    start = 0;
    check("drain_done", done, 1);
    check("drain_run", run, 0);
    check("drain_busy", busy, 1);
    repeat (4) step();
    check("sw_sel", init_sel, 5'b00010);
    check("sw_cfg", PE_config, 32'h55);
    step(); step();
    check("sw_run", run, 1);

    // Simultaneous stop and start: stop wins.
    stop = 1; start = 1; ctx_sel = 2'd1;
    step();
    stop = 0; start = 0;
    check("ss_busy", busy, 0);
    check("ss_done", done, 1);
    step();
    check("ss_no_load", init_en, 0);

    // Out-of-range slot write.
    cfg_valid = 1; cfg_ctx = 2'd0; cfg_slot = 3'd6; cfg_data = 32'h77;
    #1 check("oor_ready", cfg_ready, 1);
    step();
    cfg_valid = 0;
    check("oor_err", cfg_err, 1);
    start = 1; ctx_sel = 2'd0;
    step();
    start = 0;
    check("oor_mem", PE_config, 0);
    step();

    // Asynchronous reset in the middle of LOAD.
    #2 rst = 1'b0;
    model_reset();
    #1;
    check("arst_init_en", init_en, 0);
    check("arst_init_sel", init_sel, 0);
    check("arst_run", run, 0);
    check("arst_busy", busy, 0);
    check("arst_cfg_err", cfg_err, 0);
    step();
    rst = 1'b1;
    start = 1; ctx_sel = 2'd1;
    step();
    start = 0;
    check("arst_mem_clr", PE_config, 0);
    check("arst_sel0", init_sel, 5'b10000);

    // Randomized traffic, checked every cycle by the model.
    for (int i = 0; i < 3000; i++) begin
      cfg_valid = 1'($urandom_range(0, 1));
      cfg_ctx   = CW'($urandom_range(0, CD - 1));
      cfg_slot  = ($urandom_range(0, 15) == 0) ? SW'($urandom_range(NP + 1, 7))
                                               : SW'($urandom_range(0, NP));
      cfg_data  = $urandom;
      start     = ($urandom_range(0, 9) == 0);
      ctx_sel   = CW'($urandom_range(0, CD - 1));
      stop      = ($urandom_range(0, 14) == 0);
      step();
    end
    cfg_valid = 0; start = 0; stop = 0;
    step();
    cmp_en = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
